// File: rtl/fwd_hazard_tracker.sv
// Forwarding-select and load-use stall unit with a private shadow of in-flight destination writes.
// Optional stall-cycle performance counter enabled by defining FWD_HAZARD_PERF_EN.
module fwd_hazard_tracker #(
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 31,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ex_valid,
  input  logic                      ex_regwrite,
  input  logic                      ex_is_load,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_flush,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic [15:0]               stall_cycles
);

  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(ZERO_REG);

  // Stage k of the shadow pipeline is index k; index 1 is EX/MEM.
  logic [DEPTH:1]             v_reg;
  logic [DEPTH:1]             ld_reg;
  logic [DEPTH:1][REG_AW-1:0] rd_reg;

  logic               v_next;
  logic               ex_load_live;
  logic [NUM_SRC-1:0] port_hazard;

  assign v_next       = ex_valid & ex_regwrite & ~ex_flush & (ex_rd != ZERO_ADDR);
  assign ex_load_live = v_next & ex_is_load;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v_reg <= '0;
    end else begin
      v_reg[1] <= v_next;
      for (int k = DEPTH; k >= 2; k--) begin
        v_reg[k] <= v_reg[k-1];
      end
    end
    rd_reg[1] <= ex_rd;
    ld_reg[1] <= ex_is_load;
    for (int k = DEPTH; k >= 2; k--) begin
      rd_reg[k] <= rd_reg[k-1];
      ld_reg[k] <= ld_reg[k-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_port
      logic [REG_AW-1:0] ex_addr;
      logic [REG_AW-1:0] id_addr;
      logic [SEL_W-1:0]  sel;
      logic              hazard;

      assign ex_addr = ex_src[gi*REG_AW +: REG_AW];
      assign id_addr = id_src[gi*REG_AW +: REG_AW];

      // Scan oldest to youngest so the youngest matching producer overrides.
      always_comb begin
        sel = '0;
        for (int k = DEPTH; k >= 1; k--) begin
          if (v_reg[k] && (rd_reg[k] == ex_addr)) begin
            sel = SEL_W'(k);
          end
        end
        if ((ex_addr == ZERO_ADDR) || !reset_n) begin
          sel = '0;
        end
      end

      // The ID instruction sees every producer one stage older when it reaches EX.
      always_comb begin
        hazard = ex_load_live && (ex_rd == id_addr);
        for (int k = 1; k <= DEPTH; k++) begin
          if ((k < LOAD_LAT) && v_reg[k] && ld_reg[k] && (rd_reg[k] == id_addr)) begin
            hazard = 1'b1;
          end
        end
        if (!id_src_used[gi] || (id_addr == ZERO_ADDR) || !reset_n) begin
          hazard = 1'b0;
        end
      end

      assign fwd_sel[gi*SEL_W +: SEL_W] = sel;
      assign port_hazard[gi]            = hazard;
    end
  endgenerate

  assign stall = |port_hazard;

`ifdef FWD_HAZARD_PERF_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_reg <= 16'h0000;
    end else if (stall && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'h0001;
    end
  end

  assign stall_cycles = stall_cnt_reg;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Scoreboard bench for fwd_hazard_tracker at default parameters (NUM_SRC=2, DEPTH=2, LOAD_LAT=1).
module tb_fwd_hazard_tracker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid, ex_regwrite, ex_is_load, ex_flush;
  logic [4:0]  ex_rd;
  logic [9:0]  ex_src, id_src;
  logic [1:0]  id_src_used;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       rst;
    logic       ev;
    logic       rw;
    logic       ld;
    logic [4:0] rd;
    logic       fl;
    logic [4:0] es0;
    logic [4:0] es1;
    logic [4:0] is0;
    logic [4:0] is1;
    logic [1:0] used;
    logic [1:0] f0;
    logic [1:0] f1;
    logic       st;
  } vec_t;

  logic [4:0] exp_q[$];

  fwd_hazard_tracker dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ex_valid     (ex_valid),
    .ex_regwrite  (ex_regwrite),
    .ex_is_load   (ex_is_load),
    .ex_rd        (ex_rd),
    .ex_flush     (ex_flush),
    .ex_src       (ex_src),
    .id_src       (id_src),
    .id_src_used  (id_src_used),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic ev, input logic rw, input logic ld,
                              input logic [4:0] rd, input logic fl,
                              input logic [4:0] es0, input logic [4:0] es1,
                              input logic [4:0] is0, input logic [4:0] is1, input logic [1:0] used,
                              input logic [1:0] f0, input logic [1:0] f1, input logic st);
    vec_t v;
    v.rst = rst; v.ev = ev; v.rw = rw; v.ld = ld; v.rd = rd; v.fl = fl;
    v.es0 = es0; v.es1 = es1; v.is0 = is0; v.is1 = is1; v.used = used;
    v.f0 = f0; v.f1 = f1; v.st = st;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    reset_n     = v.rst;
    ex_valid    = v.ev;
    ex_regwrite = v.rw;
    ex_is_load  = v.ld;
    ex_rd       = v.rd;
    ex_flush    = v.fl;
    ex_src      = {v.es1, v.es0};
    id_src      = {v.is1, v.is0};
    id_src_used = v.used;
  endtask

  task automatic test_reset();
    vec_t tbl[$];
    logic [4:0] e;
    tbl.push_back(mk(0, 0,0,0, 0,0, 31,31, 31,31, 2'b00, 0,0, 0));
    tbl.push_back(mk(0, 1,1,1, 3,0,  3, 3,  3, 3, 2'b11, 0,0, 0));
    tbl.push_back(mk(0, 0,0,0, 0,0, 31,31, 31,31, 2'b00, 0,0, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      exp_q.push_back({tbl[i].f1, tbl[i].f0, tbl[i].st});
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({fwd_sel, stall} !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: fwd_sel=%h stall=%b, expected fwd_sel=%h stall=%b", i, fwd_sel, stall, e[4:1], e[0]);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (stall_cycles !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_stall_cycles: got %h, expected 0000", stall_cycles);
    end
  endtask

  task automatic test_fwd_chain();
    vec_t tbl[$];
    logic [4:0] e;
    tbl.push_back(mk(1, 1,1,0, 1,0, 31,31, 31,31, 2'b00, 0,0, 0));
    tbl.push_back(mk(1, 0,0,0, 0,0,  1,31, 31,31, 2'b00, 1,0, 0));
    tbl.push_back(mk(1, 0,0,0, 0,0,  1,31, 31,31, 2'b00, 2,0, 0));
    tbl.push_back(mk(1, 0,0,0, 0,0,  1,31, 31,31, 2'b00, 0,0, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      exp_q.push_back({tbl[i].f1, tbl[i].f0, tbl[i].st});
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({fwd_sel, stall} !== e) begin
        n_fail++;
        $display("FAIL fwd_chain[%0d]: fwd_sel=%h stall=%b, expected fwd_sel=%h stall=%b", i, fwd_sel, stall, e[4:1], e[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_youngest();
    vec_t tbl[$];
    logic [4:0] e;
    tbl.push_back(mk(1, 1,1,0, 2,0, 31,31, 31,31, 2'b00, 0,0, 0));
    tbl.push_back(mk(1, 1,1,0, 2,0, 31,31, 31,31, 2'b00, 0,0, 0));
    tbl.push_back(mk(1, 0,0,0, 0,0,  3, 2, 31,31, 2'b00, 0,1, 0));
    tbl.push_back(mk(1, 0,0,0, 0,0,  3, 2, 31,31, 2'b00, 0,2, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      exp_q.push_back({tbl[i].f1, tbl[i].f0, tbl[i].st});
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({fwd_sel, stall} !== e) begin
        n_fail++;
        $display("FAIL youngest[%0d]: fwd_sel=%h stall=%b, expected fwd_sel=%h stall=%b", i, fwd_sel, stall, e[4:1], e[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_reg();
    vec_t tbl[$];
    logic [4:0] e;
    tbl.push_back(mk(1, 1,1,0, 31,0, 31,31, 31,31, 2'b01, 0,0, 0));
    tbl.push_back(mk(1, 1,1,1, 31,0, 31,31, 31,31, 2'b11, 0,0, 0));
    tbl.push_back(mk(1, 0,0,0,  0,0, 31,31, 31,31, 2'b11, 0,0, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      exp_q.push_back({tbl[i].f1, tbl[i].f0, tbl[i].st});
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({fwd_sel, stall} !== e) begin
        n_fail++;
        $display("FAIL zero_reg[%0d]: fwd_sel=%h stall=%b, expected fwd_sel=%h stall=%b", i, fwd_sel, stall, e[4:1], e[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    vec_t tbl[$];
    logic [4:0] e;
    tbl.push_back(mk(1, 1,1,1, 3,0, 31,31,  3,31, 2'b01, 0,0, 1));
    tbl.push_back(mk(1, 0,0,0, 0,0, 31,31,  3,31, 2'b01, 0,0, 0));
    tbl.push_back(mk(1, 1,1,0, 5,0,  3,31, 31,31, 2'b00, 2,0, 0));
    tbl.push_back(mk(1, 1,1,1, 3,0, 31,31,  3,31, 2'b00, 0,0, 0));
    tbl.push_back(mk(1, 1,1,1, 6,0, 31,31, 31, 6, 2'b10, 0,0, 1));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      exp_q.push_back({tbl[i].f1, tbl[i].f0, tbl[i].st});
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({fwd_sel, stall} !== e) begin
        n_fail++;
        $display("FAIL load_use[%0d]: fwd_sel=%h stall=%b, expected fwd_sel=%h stall=%b", i, fwd_sel, stall, e[4:1], e[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    vec_t tbl[$];
    logic [4:0] e;
    tbl.push_back(mk(1, 1,1,1, 4,1, 31,31,  4,31, 2'b01, 0,0, 0));
    tbl.push_back(mk(1, 0,0,0, 0,0,  4,31, 31,31, 2'b00, 0,0, 0));
    tbl.push_back(mk(1, 0,0,0, 0,0,  4,31, 31,31, 2'b00, 0,0, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      exp_q.push_back({tbl[i].f1, tbl[i].f0, tbl[i].st});
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({fwd_sel, stall} !== e) begin
        n_fail++;
        $display("FAIL flush[%0d]: fwd_sel=%h stall=%b, expected fwd_sel=%h stall=%b", i, fwd_sel, stall, e[4:1], e[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    vec_t tbl[$];
    logic [4:0] e;
    tbl.push_back(mk(1, 1,1,0, 7,0, 31,31, 31,31, 2'b00, 0,0, 0));
    tbl.push_back(mk(1, 1,1,0, 8,0,  7,31, 31,31, 2'b00, 1,0, 0));
    tbl.push_back(mk(0, 1,1,1, 9,0,  7, 8,  9,31, 2'b01, 0,0, 0));
    tbl.push_back(mk(1, 0,0,0, 0,0,  7, 8, 31,31, 2'b00, 0,0, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      exp_q.push_back({tbl[i].f1, tbl[i].f0, tbl[i].st});
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({fwd_sel, stall} !== e) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: fwd_sel=%h stall=%b, expected fwd_sel=%h stall=%b", i, fwd_sel, stall, e[4:1], e[0]);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (stall_cycles !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_stall_cycles: got %h, expected 0000", stall_cycles);
    end
  endtask

  task automatic test_back_to_back_loads();
    vec_t tbl[$];
    logic [4:0] e;
    logic [15:0] exp_cnt;
    for (int n = 0; n < 3; n++) begin
      tbl.push_back(mk(1, 1,1,1, 10,0, 31,31, 10,31, 2'b01, 0,0, 1));
      tbl.push_back(mk(1, 0,0,0,  0,0, 31,31, 10,31, 2'b01, 0,0, 0));
    end
    foreach (tbl[i]) begin
      apply(tbl[i]);
      exp_q.push_back({tbl[i].f1, tbl[i].f0, tbl[i].st});
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({fwd_sel, stall} !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: fwd_sel=%h stall=%b, expected fwd_sel=%h stall=%b", i, fwd_sel, stall, e[4:1], e[0]);
      end
      @(posedge clk); #1;
    end
`ifdef FWD_HAZARD_PERF_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    n_checks++;
    if (stall_cycles !== exp_cnt) begin
      n_fail++;
      $display("FAIL stall_cycles: got %0d, expected %0d", stall_cycles, exp_cnt);
    end
  endtask

  initial begin
    apply(mk(0, 0,0,0, 0,0, 31,31, 31,31, 2'b00, 0,0, 0));
    test_reset();
    test_fwd_chain();
    test_youngest();
    test_zero_reg();
    test_load_use();
    test_flush();
    test_reset_mid();
    test_back_to_back_loads();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_tracker.md
Name: fwd_hazard_tracker

Overview:
- Parametrised forwarding and load-use hazard unit for the pipelined LEGv8 core; replaces the fixed 2-source, 2-stage combinational forwarding logic.
- Keeps its own registered shadow of in-flight destination writes for DEPTH post-EX stages, so the datapath does not pass EX/MEM and MEM/WB control into it.
- Produces per-source forward selects for the instruction in EX.
- Produces the ID-stage stall for load-use hazards, with configurable load latency.

Parameters:
- NUM_SRC, 2: number of source operand ports (rn, rm, ...).
- REG_AW, 5: register address width.
- ZERO_REG, 31: register index that is never forwarded or hazarded (XZR).
- DEPTH, 2: number of tracked post-EX stages (1 = EX/MEM, 2 = MEM/WB, ...). Must be ≥ 1.
- LOAD_LAT, 1: number of stages after EX/MEM before load data is forwardable. Load data is usable from stage 1+LOAD_LAT. Must satisfy 1+LOAD_LAT ≤ DEPTH.
- SEL_W, $clog2(DEPTH+1): derived; width of each forward select.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ex_valid  in  1  instruction in EX is real (not a bubble).
- ex_regwrite  in  1  EX instruction writes a register.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd  in  REG_AW  EX destination register.
- ex_flush  in  1  kill the EX instruction; it is not recorded.
- ex_src  in  NUM_SRC*REG_AW  source addresses of the EX instruction, packed; port i is at [i*REG_AW +: REG_AW].
- id_src  in  NUM_SRC*REG_AW  source addresses of the ID instruction, packed the same way.
- id_src_used  in  NUM_SRC  per-port flag: the ID instruction actually reads that port.
- fwd_sel  out  NUM_SRC*SEL_W  per port: 0 = register file, k = forward from stage k.
- stall  out  1  hold PC and IF/ID, and inject a bubble into EX next cycle.
- stall_cycles  out  16  saturating stall count (optional feature only).

Behaviour:
- State: entry[1..DEPTH], each holding {v, rd, ld}.
- Every rising edge with reset_n=1:
  - entry[1] <= {ex_valid & ex_regwrite & ~ex_flush & (ex_rd != ZERO_REG), ex_rd, ex_is_load}.
  - entry[k] <= entry[k-1] for k = 2..DEPTH.
  - entry[DEPTH] falls off.
- The shift never pauses. stall does not freeze the tracker; the datapath's bubble arrives as ex_valid=0.
- fwd_sel[i] is combinational from the current entries:
  - Value is the smallest k with entry[k].v and entry[k].rd == ex_src[i] and ex_src[i] != ZERO_REG.
  - The youngest producer wins.
  - No match gives 0.
  - A load entry at k < 1+LOAD_LAT still matches. This case is unreachable when stall is honoured and is not flagged.
- Load-use prediction: the ID instruction enters EX next cycle, so each producer will be one stage older.
  - The EX instruction (ex_valid & ex_regwrite & ex_is_load & ~ex_flush & rd != ZERO_REG) is a hazard because 1 < 1+LOAD_LAT.
  - entry[k] with ld=1 is a hazard iff k+1 < 1+LOAD_LAT.
- stall = OR over ports i with id_src_used[i] of a hazard producer whose rd == id_src[i], also requiring id_src[i] != ZERO_REG.
  - stall is combinational.
  - It repeats each cycle until no hazard remains, giving exactly LOAD_LAT stall cycles per dependent load.
- ex_flush together with ex_valid: the EX instruction is neither recorded nor a hazard source for that cycle.
- Reset: on an edge with reset_n=0, all entry.v <= 0.
  - Outputs then read fwd_sel=0 and stall=0, unless the EX load term is active; that term is gated by reset_n=0.
  - stall_cycles <= 0.
  - A mid-operation reset drops all in-flight records.
- Reset values:
  - fwd_sel and stall are combinational outputs; the gating above makes them read 0 while reset_n=0.
  - stall_cycles is registered and resets to 0.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- Defined: stall_cycles increments by 1 on every edge where stall=1 and reset_n=1, and saturates at 16'hFFFF.
- Not defined: stall_cycles is tied to 16'h0000 and no counter flops are inferred.

Test Plan:
All scenarios use defaults (NUM_SRC=2, DEPTH=2, LOAD_LAT=1).
- ADD X1 in EX at cycle 0, then ex_src0=X1 → fwd_sel0=1 at cycle 1, 2 at cycle 2, 0 at cycle 3.
- Writers of X2 at stages 1 and 2 simultaneously, ex_src1=X2 → fwd_sel1=1 (youngest wins); ex_src0=X3 → fwd_sel0=0.
- Writer of X31 (regwrite=1), then ex_src0=X31 → fwd_sel0=0, stall=0.
- LDUR X3 in EX, id_src0=X3, id_src_used=2'b01 → stall=1 for exactly one cycle; bubble in EX next cycle → stall=0; consumer in EX → fwd_sel0=2. Repeat with id_src_used=2'b00 → stall=0.
- Load X4 with ex_flush=1, id_src0=X4 → stall=0; following cycle ex_src0=X4 → fwd_sel0=0.
- Two producers in flight, reset_n=0 for one edge → fwd_sel=0, stall=0, stall_cycles=0. With FWD_HAZARD_PERF_EN defined, three dependent loads → stall_cycles=3.
